// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot: holds one decoded instruction, detects load-use hazards,
// and forwards EX/MEM and MEM/WB results into the held operands.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_alu_control,
    input  logic [1:0]      id_src_a,
    input  logic            id_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic [4:0]      exm_rd_addr,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [4:0]      ex_alu_control,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read
);

    localparam logic [4:0] ALU_ADD = 5'd0;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_alu_control;
    logic [1:0]      r_src_a;
    logic            r_src_b;
    logic            r_reg_write;
    logic            r_mem_read;

    logic            w_load_use;
    logic            w_accept;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // A load in the slot whose result is needed by the incoming instruction must stall one cycle.
    assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd_addr != 5'd0) &
                        (((r_rd_addr == id_rs1_addr) & (id_src_a == 2'd0)) |
                         (r_rd_addr == id_rs2_addr));
    assign id_ready   = ~reset & ~w_load_use & (~r_valid | ex_ready);
    assign w_accept   = id_valid & id_ready;

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exm_reg_write && (exm_rd_addr == r_rs1_addr) && (r_rs1_addr != 5'd0))
            w_fwd_rs1 = exm_result;
        else if (wb_reg_write && (wb_rd_addr == r_rs1_addr) && (r_rs1_addr != 5'd0))
            w_fwd_rs1 = wb_result;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (exm_reg_write && (exm_rd_addr == r_rs2_addr) && (r_rs2_addr != 5'd0))
            w_fwd_rs2 = exm_result;
        else if (wb_reg_write && (wb_rd_addr == r_rs2_addr) && (r_rs2_addr != 5'd0))
            w_fwd_rs2 = wb_result;
    end

    always_comb begin
        case (r_src_a)
            2'd0:    ex_a = w_fwd_rs1;
            2'd1:    ex_a = r_pc;
            default: ex_a = '0;
        endcase
    end

    assign ex_b           = r_src_b ? r_imm : w_fwd_rs2;
    assign ex_store_data  = w_fwd_rs2;
    assign ex_valid       = r_valid;
    assign ex_alu_control = r_alu_control;
    assign ex_pc          = r_pc;
    assign ex_rd_addr     = r_rd_addr;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;

    // Priority: reset, flush, capture, stalled operand refresh, then drain/bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_rs1_addr    <= 5'd0;
            r_rs2_addr    <= 5'd0;
            r_rd_addr     <= 5'd0;
            r_imm         <= '0;
            r_alu_control <= ALU_ADD;
            r_src_a       <= 2'd0;
            r_src_b       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_pc          <= id_pc;
            r_rs1_data    <= id_rs1_data;
            r_rs2_data    <= id_rs2_data;
            r_rs1_addr    <= id_rs1_addr;
            r_rs2_addr    <= id_rs2_addr;
            r_rd_addr     <= id_rd_addr;
            r_imm         <= id_imm;
            r_alu_control <= id_alu_control;
            r_src_a       <= id_src_a;
            r_src_b       <= id_src_b;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
        end else if (r_valid && !ex_ready) begin
            // Keep forwarded values so they survive the producer leaving the pipeline.
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end else begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, forwarding,
// stall refresh, load-use bubble and flush behaviour.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, flush, id_valid, id_ready;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_control;
    logic [1:0]      id_src_a;
    logic            id_src_b, id_reg_write, id_mem_read;
    logic [4:0]      exm_rd_addr, wb_rd_addr;
    logic            exm_reg_write, wb_reg_write;
    logic [XLEN-1:0] exm_result, wb_result;
    logic            ex_ready, ex_valid;
    logic [4:0]      ex_alu_control, ex_rd_addr;
    logic [XLEN-1:0] ex_a, ex_b, ex_store_data, ex_pc;
    logic            ex_reg_write, ex_mem_read;

    int checkCount = 0;
    int failCount  = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_imm(id_imm), .id_alu_control(id_alu_control),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [31:0] rs1Data,
                                 input logic [4:0] rs2, input logic [31:0] rs2Data,
                                 input logic [4:0] rd, input logic [31:0] imm,
                                 input logic [4:0] alu, input logic [1:0] srcA,
                                 input logic srcB, input logic regWrite, input logic memRead);
        id_valid       = valid;
        id_pc          = pc;
        id_rs1_addr    = rs1;
        id_rs1_data    = rs1Data;
        id_rs2_addr    = rs2;
        id_rs2_data    = rs2Data;
        id_rd_addr     = rd;
        id_imm         = imm;
        id_alu_control = alu;
        id_src_a       = srcA;
        id_src_b       = srcB;
        id_reg_write   = regWrite;
        id_mem_read    = memRead;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b1; ex_ready = 1'b1;
        exm_rd_addr = 5'd0; exm_reg_write = 1'b0; exm_result = '0;
        wb_rd_addr = 5'd0; wb_reg_write = 1'b0; wb_result = '0;
        applyStimulus(1'b1, 32'h500, 5'd3, 32'h9, 5'd4, 32'h8, 5'd12, 32'h1, 5'd7, 2'd1, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("ready_in_reset", id_ready, 0);
        tick();
        checkOutput("rst_valid", ex_valid, 0);
        checkOutput("rst_reg_write", ex_reg_write, 0);
        checkOutput("rst_mem_read", ex_mem_read, 0);
        checkOutput("rst_rd", ex_rd_addr, 0);
        checkOutput("rst_pc", ex_pc, 0);
        checkOutput("rst_alu", ex_alu_control, 0);
        checkOutput("rst_a", ex_a, 0);
        reset = 1'b0; flush = 1'b0; id_valid = 1'b0;
        #1;
        checkOutput("ready_after_rst", id_ready, 1);

        // addi x5,x0,7
        applyStimulus(1'b1, 32'h10, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h7, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        checkOutput("addi_valid", ex_valid, 1);
        checkOutput("addi_a", ex_a, 0);
        checkOutput("addi_b", ex_b, 7);
        checkOutput("addi_rd", ex_rd_addr, 5);
        checkOutput("addi_pc", ex_pc, 32'h10);
        tick();
        checkOutput("drain_valid", ex_valid, 0);
        checkOutput("drain_rw", ex_reg_write, 0);

        // Forwarding priority on rs1=x5
        ex_ready = 1'b0;
        applyStimulus(1'b1, 32'h40, 5'd5, 32'h100, 5'd0, 32'h5, 5'd10, 32'h0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        exm_rd_addr = 5'd5; exm_result = 32'h11; exm_reg_write = 1'b1;
        wb_rd_addr = 5'd5; wb_result = 32'h22; wb_reg_write = 1'b1;
        #1;
        checkOutput("fwd_exm_prio", ex_a, 32'h11);
        exm_reg_write = 1'b0;
        #1;
        checkOutput("fwd_wb", ex_a, 32'h22);
        wb_reg_write = 1'b0;
        #1;
        checkOutput("fwd_none", ex_a, 32'h100);
        checkOutput("stall_ready", id_ready, 0);
        ex_ready = 1'b1;
        tick();

        // x0 is never forwarded
        ex_ready = 1'b0;
        applyStimulus(1'b1, 32'h44, 5'd0, 32'h0, 5'd0, 32'h5, 5'd11, 32'h0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        exm_rd_addr = 5'd0; exm_result = 32'hFFFF_FFFF; exm_reg_write = 1'b1;
        wb_rd_addr = 5'd0; wb_result = 32'hAAAA_AAAA; wb_reg_write = 1'b1;
        #1;
        checkOutput("x0_a", ex_a, 0);
        checkOutput("x0_store", ex_store_data, 5);
        exm_reg_write = 1'b0; wb_reg_write = 1'b0;
        ex_ready = 1'b1;
        tick();

        // Stalled operand refresh on rs2=x8
        ex_ready = 1'b0;
        applyStimulus(1'b1, 32'h48, 5'd0, 32'h0, 5'd8, 32'h44, 5'd12, 32'h0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        id_valid = 1'b0;
        exm_rd_addr = 5'd8; exm_result = 32'h33; exm_reg_write = 1'b1;
        #1;
        checkOutput("hold_c1_b", ex_b, 32'h33);
        tick();
        exm_reg_write = 1'b0;
        #1;
        checkOutput("hold_c2_b", ex_b, 32'h33);
        checkOutput("hold_c2_store", ex_store_data, 32'h33);
        checkOutput("hold_c2_valid", ex_valid, 1);
        checkOutput("hold_c2_rd", ex_rd_addr, 12);
        tick();
        checkOutput("hold_c3_b", ex_b, 32'h33);
        ex_ready = 1'b1;
        tick();

        // Load-use: lw x6 then add x7,x6,x1
        applyStimulus(1'b1, 32'h80, 5'd2, 32'h0, 5'd0, 32'h0, 5'd6, 32'h4, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h84, 5'd6, 32'h0, 5'd1, 32'h0, 5'd7, 32'h0, 5'd0, 2'd1, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("lu_pc_src_ready", id_ready, 1);
        id_src_a = 2'd0;
        #1;
        checkOutput("lu_ready", id_ready, 0);
        tick();
        checkOutput("bubble_valid", ex_valid, 0);
        checkOutput("bubble_mr", ex_mem_read, 0);
        checkOutput("bubble_rw", ex_reg_write, 0);
        checkOutput("bubble_ready", id_ready, 1);
        tick();
        checkOutput("add_valid", ex_valid, 1);
        checkOutput("add_rd", ex_rd_addr, 7);

        // Flush kills held and incoming instruction
        applyStimulus(1'b1, 32'h200, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h0, 5'd3, 2'd1, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("flush_ready", id_ready, 1);
        tick();
        checkOutput("flush_valid", ex_valid, 0);
        checkOutput("flush_rw", ex_reg_write, 0);
        checkOutput("flush_no_capture", ex_rd_addr, 7);
        flush = 1'b0;
        tick();
        checkOutput("cap_rd", ex_rd_addr, 9);
        checkOutput("cap_alu", ex_alu_control, 3);
        checkOutput("cap_a_pc", ex_a, 32'h200);
        reset = 1'b1; flush = 1'b1;
        tick();
        checkOutput("rf_valid", ex_valid, 0);
        checkOutput("rf_rd", ex_rd_addr, 0);
        checkOutput("rf_pc", ex_pc, 0);
        checkOutput("rf_alu", ex_alu_control, 0);
        checkOutput("rf_rw", ex_reg_write, 0);
        reset = 1'b0; flush = 1'b0; id_valid = 1'b0;
        #1;
        checkOutput("rf_ready", id_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
